// File: rtl/lvds_pkg.sv
// Shared types and constants for the LVDS transmit scheduler.
// Holds the FSM state encoding, the default training word and the burst-counter helper.
package lvds_pkg;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StTrain = 2'd1,
    StArb   = 2'd2,
    StSend  = 2'd3
  } state_e;

  localparam int unsigned CntW = 8;
  localparam logic [7:0] TrainPatternDefault = 8'hA5;

  // Word counters saturate instead of wrapping.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/lvds_tx_scheduler_if.sv
// Requester/transmitter bundle of the LVDS transmit scheduler.
// The slave modport is the scheduler; master is the surrounding requesters and transmitter.
interface lvds_tx_scheduler_if #(
  parameter int unsigned PARALLEL_WIDTH = 8,
  parameter int unsigned NUM_REQ        = 4
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ*PARALLEL_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic                              train_req;
  logic [PARALLEL_WIDTH-1:0]         tx_data_in;
  logic                              tx_data_valid;
  logic                              tx_data_ready;
  logic [IdxW-1:0]                   grant_id;
  logic                              busy;

  modport master (
    output req_data, req_valid, train_req, tx_data_ready,
    input  req_ready, tx_data_in, tx_data_valid, grant_id, busy
  );

  modport slave (
    input  req_data, req_valid, train_req, tx_data_ready,
    output req_ready, tx_data_in, tx_data_valid, grant_id, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority selector.
// The search starts one past the last granted channel and wraps modulo NUM_REQ.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IdxW-1:0]    i_last_grant,
  output logic [IdxW-1:0]    o_grant,
  output logic               o_any_req
);

  logic [IdxW-1:0] w_idx;

  always_comb begin
    o_grant   = '0;
    o_any_req = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = IdxW'((32'(i_last_grant) + k) % NUM_REQ);
      if (!o_any_req && i_req[w_idx]) begin
        o_grant   = w_idx;
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lvds_tx_scheduler.sv
// Schedules requester words and link-training sequences onto one LVDS transmitter.
// Bursts of up to MAX_BURST words per grant; training runs after reset and on request.
module lvds_tx_scheduler
  import lvds_pkg::*;
#(
  parameter  int unsigned               PARALLEL_WIDTH = 8,
  parameter  int unsigned               NUM_REQ        = 4,
  parameter  int unsigned               MAX_BURST      = 4,
  parameter  int unsigned               TRAIN_WORDS    = 16,
  parameter  logic [PARALLEL_WIDTH-1:0] TRAIN_PATTERN  = PARALLEL_WIDTH'(TrainPatternDefault),
  localparam int unsigned               IdxW           = $clog2(NUM_REQ)
) (
  input logic                clk_sys,
  input logic                reset_n,
  lvds_tx_scheduler_if.slave bus
);

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [IdxW-1:0] r_grant;
  logic [IdxW-1:0] r_last_grant;
  logic            r_pend;

  logic [PARALLEL_WIDTH-1:0] w_words [NUM_REQ];
  logic [IdxW-1:0]           w_arb_grant;
  logic                      w_any_req;
  logic                      w_sel_valid;
  logic                      w_fire;
  logic                      w_send_done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign w_words[g] = bus.req_data[g*PARALLEL_WIDTH +: PARALLEL_WIDTH];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req        (bus.req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_arb_grant),
    .o_any_req    (w_any_req)
  );

  assign w_sel_valid = bus.req_valid[r_grant];
  assign w_fire      = w_sel_valid && bus.tx_data_ready;
  // Burst ends on the MAX_BURST-th beat or as soon as the granted channel drops valid.
  assign w_send_done = !w_sel_valid || (w_fire && (r_cnt == CntW'(MAX_BURST - 1)));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StInit;
      r_cnt        <= '0;
      r_grant      <= '0;
      r_last_grant <= IdxW'(NUM_REQ - 1);
      r_pend       <= 1'b0;
    end else begin
      unique case (r_state)
        StInit: begin
          r_state <= StTrain;
          r_cnt   <= '0;
        end
        StTrain: begin
          if (bus.tx_data_ready) begin
            if (r_cnt == CntW'(TRAIN_WORDS - 1)) begin
              r_state <= StArb;
              r_cnt   <= '0;
            end else begin
              r_cnt <= sat_inc(r_cnt);
            end
          end
        end
        StArb: begin
          if (bus.train_req) begin
            r_state <= StTrain;
            r_cnt   <= '0;
          end else if (w_any_req) begin
            r_grant <= w_arb_grant;
            r_cnt   <= '0;
            r_state <= StSend;
          end
        end
        StSend: begin
          if (w_send_done) begin
            r_last_grant <= r_grant;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_state      <= (r_pend || bus.train_req) ? StTrain : StArb;
          end else begin
            if (bus.train_req) r_pend <= 1'b1;
            if (w_fire) r_cnt <= sat_inc(r_cnt);
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  // Data path is combinational from the registered state and grant.
  always_comb begin
    bus.tx_data_in    = '0;
    bus.tx_data_valid = 1'b0;
    bus.req_ready     = '0;
    unique case (r_state)
      StTrain: begin
        bus.tx_data_in    = TRAIN_PATTERN;
        bus.tx_data_valid = 1'b1;
      end
      StSend: begin
        bus.tx_data_in         = w_words[r_grant];
        bus.tx_data_valid      = w_sel_valid;
        bus.req_ready[r_grant] = bus.tx_data_ready;
      end
      default: ;
    endcase
  end

  assign bus.grant_id = r_grant;
  assign bus.busy     = (r_state == StTrain) || (r_state == StSend);

endmodule

// File: doc/lvds_tx_scheduler.md
LVDS_TX_SCHEDULER -- requirements
Module: lvds_tx_scheduler

Interface
REQ-001 Parameter PARALLEL_WIDTH, default 8: word width of every data port.
REQ-002 Parameter NUM_REQ, default 4: number of requester channels, range 2..8.
REQ-003 Parameter MAX_BURST, default 4: maximum words accepted per grant, range 1..255.
REQ-004 Parameter TRAIN_WORDS, default 16: training words sent per training sequence, range 1..255.
REQ-005 Parameter TRAIN_PATTERN, default 'hA5: training word value, PARALLEL_WIDTH bits.
REQ-006 Ports: one clock, clk_sys; reset reset_n is asynchronous and active-low.
REQ-007 clk_sys  input  1  system-domain clock; all logic on its rising edge.
REQ-008 reset_n  input  1  asynchronous active-low reset.
REQ-009 req_data  input  NUM_REQ*PARALLEL_WIDTH  requester words; channel i occupies bits [i*PARALLEL_WIDTH +: PARALLEL_WIDTH].
REQ-010 req_valid  input  NUM_REQ  per-channel word valid.
REQ-011 req_ready  output  NUM_REQ  per-channel word accepted when paired with req_valid.
REQ-012 train_req  input  1  single-cycle pulse requesting a retraining sequence.
REQ-013 tx_data_in  output  PARALLEL_WIDTH  word to the LVDS transmitter.
REQ-014 tx_data_valid  output  1  word valid to the transmitter.
REQ-015 tx_data_ready  input  1  transmitter ready; a transfer is tx_data_valid AND tx_data_ready in one cycle.
REQ-016 grant_id  output  clog2(NUM_REQ)  channel currently granted.
REQ-017 busy  output  1  high in TRAIN or SEND.

Function
REQ-018 States SHALL be INIT, TRAIN, ARB and SEND; the reset state is INIT.
REQ-019 INIT SHALL last one cycle, with all outputs low, then move to TRAIN with the word counter at 0.
REQ-020 In TRAIN, tx_data_in SHALL be TRAIN_PATTERN, tx_data_valid 1 and all req_ready 0.
REQ-021 In TRAIN, the counter SHALL increment on each transfer; after TRAIN_WORDS transfers the block SHALL move to ARB.
REQ-022 In ARB, tx_data_valid and req_ready SHALL be 0.
REQ-023 In ARB with any req_valid high, the block SHALL grant round-robin, starting the search at last_grant+1 modulo NUM_REQ, register grant_id, clear the counter and move to SEND.
REQ-024 In ARB with no req_valid high, the block SHALL stay in ARB; each grant costs exactly one bubble cycle.
REQ-025 In SEND, the data path SHALL be combinational from the granted channel: tx_data_in = req_data[grant_id], tx_data_valid = req_valid[grant_id], req_ready[grant_id] = tx_data_ready, and all other req_ready 0.
REQ-026 SEND SHALL exit to ARB after the MAX_BURST-th transfer, or in any cycle where req_valid[grant_id] is 0.
REQ-027 On SEND exit, last_grant SHALL be set to grant_id.
REQ-028 After reset, last_grant SHALL be NUM_REQ-1, so channel 0 has first priority.
REQ-029 Burst counter arithmetic SHALL use 8 bits with no wrap; the MAX_BURST compare precedes the increment.
REQ-030 A train_req received in ARB SHALL move the block to TRAIN next cycle, with priority over any grant.
REQ-031 A train_req received in SEND SHALL set a pending flag; the burst SHALL finish, then the block SHALL go to TRAIN instead of ARB and clear the flag.
REQ-032 A train_req received in TRAIN SHALL be ignored.
REQ-033 A train_req coinciding with SEND exit SHALL route the block to TRAIN.
REQ-034 Round-robin search wrap-around: from last_grant = NUM_REQ-1 the search SHALL begin at channel 0.

Reset
REQ-035 Reset assertion SHALL force, asynchronously and in any state: state INIT; tx_data_in 0, tx_data_valid 0, req_ready all 0, grant_id 0, busy 0; counter 0; pending flag 0; last_grant NUM_REQ-1.
REQ-036 A burst in progress SHALL be abandoned without any further transfer.

Structure
REQ-037 State encoding and the TRAIN_PATTERN default SHALL live in the shared package lvds_pkg.
REQ-038 The round-robin priority selector SHALL be one sub-module, rr_arbiter (inputs: request vector and last_grant; outputs: grant index and any_req), purely combinational.

Verification
REQ-039 Reset release with tx_data_ready held 1 -> exactly 16 words of 8'hA5 on consecutive cycles, then ARB.
REQ-040 Channels 0..3 all valid continuously, MAX_BURST=4 -> bursts of 4 in grant order 0,1,2,3,0, one bubble between bursts.
REQ-041 Only channel 2 valid, 2 words then drops -> 2 transfers, SEND exits to ARB, and the next grant goes to channel 2 again when it reasserts.
REQ-042 tx_data_ready toggles every other cycle during a burst -> no word lost or duplicated, and req_ready mirrors tx_data_ready.
REQ-043 train_req in the second beat of a burst -> the burst completes 4 words, then 16 training words, then arbitration resumes from last_grant+1.
REQ-044 reset_n low mid-burst -> all outputs 0 immediately; after release the INIT then TRAIN sequence repeats.
